// File: rtl/hex_disp_pkg.sv
// Shared constants and the page-state type for the hex display front end.
package hex_disp_pkg;

  localparam logic PAGE_LO = 1'b0;
  localparam logic PAGE_HI = 1'b1;

  localparam int unsigned HEX_DIGITS  = 6;
  localparam int unsigned DISP_BITS   = 24;
  localparam int unsigned HI_BYTE_MSB = 31;
  localparam int unsigned HI_BYTE_LSB = 24;

  typedef enum logic {
    StLo = PAGE_LO,
    StHi = PAGE_HI
  } page_e;

endpackage

// File: rtl/tick_counter.sv
// Free-running modulo-MAX counter with enable, synchronous clear and terminal flag.
module tick_counter #(
  parameter int unsigned MAX = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_en,
  input  logic                   i_clr,
  output logic [$clog2(MAX)-1:0] o_count,
  output logic                   o_term
);

  localparam int unsigned W = $clog2(MAX);

  logic [W-1:0] r_count;

  assign o_count = r_count;
  assign o_term  = (r_count == W'(MAX - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= o_term ? '0 : r_count + W'(1);
    end
  end

endmodule

// File: rtl/hex_page_ctrl.sv
// Source selector, periodic snapshot and low/high-byte paging for the six-digit hex display.
module hex_page_ctrl
  import hex_disp_pkg::*;
#(
  parameter int unsigned NUM_SRC        = 4,
  parameter int unsigned REFRESH_CYCLES = 5000000,
  parameter int unsigned DWELL_CYCLES   = 50000000
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [NUM_SRC*32-1:0]      i_src_vals,
  input  logic                       i_next_btn,
  input  logic                       i_freeze,
  output logic [31:0]                o_disp_val,
  output logic                       o_page_hi,
  output logic [$clog2(NUM_SRC)-1:0] o_src_idx
);

  localparam int unsigned IDX_W = $clog2(NUM_SRC);
  localparam int unsigned REF_W = $clog2(REFRESH_CYCLES);
  localparam int unsigned DWL_W = $clog2(DWELL_CYCLES);

  page_e            r_page;
  logic [IDX_W-1:0] r_src_idx;
  logic [31:0]      r_snap;
  logic             r_btn_q;
  logic             r_reload_pend;

  logic             w_rise;
  logic             w_load;
  logic             w_paging;
  logic             w_refresh_term;
  logic             w_dwell_term;
  logic [REF_W-1:0] w_refresh_cnt;
  logic [DWL_W-1:0] w_dwell_cnt;
  logic [31:0]      w_src_sel;
  logic             w_unused_cnt;

  assign w_rise       = i_next_btn & ~r_btn_q;
  assign w_load       = (w_refresh_term | r_reload_pend) & ~i_freeze;
  assign w_paging     = (r_snap[HI_BYTE_MSB:HI_BYTE_LSB] != '0);
  assign w_unused_cnt = ^{w_refresh_cnt, w_dwell_cnt};

  always_comb begin
    w_src_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (r_src_idx == IDX_W'(i)) w_src_sel = i_src_vals[32*i +: 32];
    end
  end

  tick_counter #(.MAX(REFRESH_CYCLES)) u_refresh (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (1'b1),
    .i_clr   (1'b0),
    .o_count (w_refresh_cnt),
    .o_term  (w_refresh_term)
  );

  tick_counter #(.MAX(DWELL_CYCLES)) u_dwell (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (w_paging & ~i_freeze),
    .i_clr   (w_rise | ~w_paging),
    .o_count (w_dwell_cnt),
    .o_term  (w_dwell_term)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_src_idx     <= '0;
      r_snap        <= '0;
      r_page        <= StLo;
      r_btn_q       <= 1'b0;
      r_reload_pend <= 1'b1;
    end else begin
      r_btn_q <= i_next_btn;
      if (w_load) begin
        r_snap        <= w_src_sel;
        r_reload_pend <= 1'b0;
      end
      // A rise after a same-cycle load re-arms the reload so the new source follows next cycle.
      if (w_rise) begin
        r_src_idx     <= (r_src_idx == IDX_W'(NUM_SRC - 1)) ? '0 : r_src_idx + IDX_W'(1);
        r_reload_pend <= 1'b1;
        r_page        <= StLo;
      end else if (!w_paging) begin
        r_page <= StLo;
      end else if (!i_freeze && w_dwell_term) begin
        r_page <= (r_page == StLo) ? StHi : StLo;
      end
    end
  end

  always_comb begin
    if (r_page == StHi) o_disp_val = {24'h000000, r_snap[HI_BYTE_MSB:HI_BYTE_LSB]};
    else                o_disp_val = {8'h00, r_snap[DISP_BITS-1:0]};
  end

  assign o_page_hi = (r_page == StHi);
  assign o_src_idx = r_src_idx;

endmodule

// File: tb/tb_hex_page_ctrl.sv
// Self-checking bench for hex_page_ctrl: directed scenarios plus randomized run against a model.
module tb_hex_page_ctrl;

  localparam int unsigned N   = 3;
  localparam int unsigned REF = 4;
  localparam int unsigned DW  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          btn = 1'b0;
  logic          frz = 1'b0;
  logic [31:0]   src [N];
  logic [N*32-1:0] src_vals;
  logic [31:0]   disp;
  logic          page_hi;
  logic [1:0]    idx;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int          m_idx   = 0;
  int          m_ref   = 0;
  int          m_dwell = 0;
  logic [31:0] m_snap  = '0;
  bit          m_page  = 0;
  bit          m_btn   = 0;
  bit          m_pend  = 1;

  always #5 clk = ~clk;

  always_comb begin
    src_vals = '0;
    for (int i = 0; i < N; i++) src_vals[32*i +: 32] = src[i];
  end

  hex_page_ctrl #(
    .NUM_SRC        (N),
    .REFRESH_CYCLES (REF),
    .DWELL_CYCLES   (DW)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_src_vals (src_vals),
    .i_next_btn (btn),
    .i_freeze   (frz),
    .o_disp_val (disp),
    .o_page_hi  (page_hi),
    .o_src_idx  (idx)
  );

  function automatic logic [31:0] m_disp();
    return m_page ? {24'h0, m_snap[31:24]} : {8'h0, m_snap[23:0]};
  endfunction

  // Advance the model by one clock from the current inputs, then step the DUT.
  task automatic tick();
    bit rise, load, paging;
    logic [31:0] nsnap;
    if (rst) begin
      m_idx = 0; m_snap = '0; m_page = 0; m_ref = 0; m_dwell = 0; m_btn = 0; m_pend = 1;
    end else begin
      rise   = btn && !m_btn;
      load   = ((m_ref == REF - 1) || m_pend) && !frz;
      paging = (m_snap[31:24] != 8'h00);
      nsnap  = load ? src[m_idx] : m_snap;
      if (load) m_pend = 0;
      if (rise) begin
        m_idx = (m_idx + 1) % N; m_pend = 1; m_page = 0; m_dwell = 0;
      end else if (!paging) begin
        m_page = 0; m_dwell = 0;
      end else if (!frz) begin
        if (m_dwell == DW - 1) begin m_dwell = 0; m_page = !m_page; end
        else m_dwell++;
      end
      m_snap = nsnap;
      m_ref  = (m_ref + 1) % REF;
      m_btn  = btn;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    src[0] = 32'h00123456; src[1] = 32'h0; src[2] = 32'h0;
    rst = 1; tick(); tick();
    total++; if (disp !== 32'h0) begin bad++; $display("FAIL reset_disp got=%h exp=0", disp); end
    total++; if (page_hi !== 1'b0) begin bad++; $display("FAIL reset_page got=%b exp=0", page_hi); end
    total++; if (idx !== 2'd0) begin bad++; $display("FAIL reset_idx got=%0d exp=0", idx); end
    rst = 0; tick();
    total++;
    if (disp !== 32'h00123456) begin bad++; $display("FAIL first_load got=%h exp=00123456", disp); end
    for (int k = 0; k < 100; k++) begin
      tick();
      total++;
      if (page_hi !== 1'b0 || disp !== 32'h00123456) begin
        bad++; $display("FAIL no_paging cyc=%0d got=%h/%b exp=00123456/0", k, disp, page_hi);
      end
    end
  endtask

  task automatic test_paging();
    int w = 0;
    src[0] = 32'hAB123456;
    while (m_snap !== 32'hAB123456 && w < 10) begin tick(); w++; end
    total++;
    if (m_snap !== 32'hAB123456) begin bad++; $display("FAIL paging_load_timeout got=%h", disp); end
    for (int k = 0; k < 40; k++) begin
      logic [31:0] e;
      e = ((k / 8) % 2 == 1) ? 32'h000000AB : 32'h00123456;
      total++;
      if (disp !== e || page_hi !== ((k / 8) % 2 == 1)) begin
        bad++; $display("FAIL paging cyc=%0d got=%h/%b exp=%h", k, disp, page_hi, e);
      end
      tick();
    end
  endtask

  task automatic test_step();
    int w = 0;
    logic [1:0]  e_idx  [3] = '{2'd1, 2'd2, 2'd0};
    logic [31:0] e_disp [3] = '{32'd2, 32'd3, 32'd1};
    src[0] = 32'd1; src[1] = 32'd2; src[2] = 32'd3;
    rst = 1; tick(); rst = 0; tick();
    for (int p = 0; p < 3; p++) begin
      btn = 1; tick(); btn = 0;
      total++;
      if (idx !== e_idx[p]) begin bad++; $display("FAIL step_idx p=%0d got=%0d exp=%0d", p, idx, e_idx[p]); end
      tick();
      total++;
      if (disp !== e_disp[p]) begin bad++; $display("FAIL step_disp p=%0d got=%h exp=%h", p, disp, e_disp[p]); end
      repeat (8) tick();
    end
    src[0] = 32'hCD000001; src[1] = 32'hEF000002;
    while (!m_page && w < 60) begin tick(); w++; end
    total++;
    if (!m_page || page_hi !== 1'b1) begin
      bad++; $display("FAIL hi_page_wait got=%b exp=1", page_hi);
    end
    btn = 1; tick(); btn = 0;
    total++; if (page_hi !== 1'b0) begin bad++; $display("FAIL rise_in_hi got=%b exp=0", page_hi); end
    tick();
    total++;
    if (disp !== 32'h00000002) begin bad++; $display("FAIL rise_in_hi_disp got=%h exp=00000002", disp); end
  endtask

  task automatic test_hold();
    int exp_idx;
    exp_idx = (m_idx + 1) % N;
    btn = 1;
    for (int k = 0; k < 20; k++) begin
      tick();
      total++;
      if (idx !== 2'(exp_idx)) begin bad++; $display("FAIL hold cyc=%0d got=%0d exp=%0d", k, idx, exp_idx); end
    end
    btn = 0; tick();
  endtask

  task automatic test_freeze();
    src[0] = 32'd1; src[1] = 32'd2; src[2] = 32'd3;
    rst = 1; tick(); rst = 0; repeat (3) tick();
    frz = 1; src[0] = 32'd5;
    btn = 1; tick(); btn = 0;
    for (int k = 0; k < 10; k++) begin
      total++;
      if (disp !== 32'd1 || page_hi !== 1'b0 || idx !== 2'd1) begin
        bad++; $display("FAIL frozen cyc=%0d got=%h/%b/%0d exp=1/0/1", k, disp, page_hi, idx);
      end
      tick();
    end
    frz = 0; tick();
    total++; if (disp !== 32'd2) begin bad++; $display("FAIL unfreeze got=%h exp=2", disp); end
  endtask

  task automatic test_reset_mid();
    int w = 0;
    src[0] = 32'hCD111111; src[1] = 32'hEF222222; src[2] = 32'h9A333333;
    while (!(m_page && m_dwell == 5) && w < 100) begin tick(); w++; end
    total++;
    if (!(m_page && m_dwell == 5) || page_hi !== 1'b1) begin
      bad++; $display("FAIL mid_wait got=%b exp=1", page_hi);
    end
    rst = 1; tick();
    total++;
    if (disp !== 32'h0 || page_hi !== 1'b0 || idx !== 2'd0) begin
      bad++; $display("FAIL mid_reset got=%h/%b/%0d exp=0/0/0", disp, page_hi, idx);
    end
    rst = 0; tick();
    total++;
    if (disp !== 32'h00111111) begin bad++; $display("FAIL mid_reload got=%h exp=00111111", disp); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        src[$urandom_range(0, N - 1)] = $urandom_range(0, 1) ? $urandom : ($urandom & 32'h00FFFFFF);
      end
      btn = ($urandom_range(0, 5) == 0) ? ~btn : btn;
      if ($urandom_range(0, 19) == 0) frz = ~frz;
      rst = ($urandom_range(0, 199) == 0);
      tick();
      total++;
      if (disp !== m_disp() || page_hi !== m_page || idx !== 2'(m_idx)) begin
        bad++;
        $display("FAIL random cyc=%0d got=%h/%b/%0d exp=%h/%b/%0d",
                 k, disp, page_hi, idx, m_disp(), m_page, m_idx);
      end
    end
    rst = 0; frz = 0; btn = 0;
  endtask

  initial begin
    test_reset();
    test_paging();
    test_step();
    test_hold();
    test_freeze();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hex_page_ctrl.md
Name: hex_page_ctrl

Overview:
Display controller in front of the six-digit hex display decoder. Selects one of NUM_SRC 32-bit debug values (PC, instruction, register, bus data, ...) via a step button and snapshots it at a human-readable refresh rate. Values wider than 24 bits are shown by automatic paging between the low 24 bits and the high byte. Output disp_val drives the 32-bit input of the six-digit hex decoder; page_hi drives an indicator LED.

Parameters:
NUM_SRC, 4, number of selectable 32-bit sources (>=2)
REFRESH_CYCLES, 5000000, clk cycles between snapshot loads (>=2)
DWELL_CYCLES, 50000000, clk cycles each page is shown when paging (>=2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
src_vals  in  NUM_SRC*32  packed sources; source i = src_vals[32*i+31:32*i]
next_btn  in  1  debounced, clk-synchronous level; rising edge selects next source
freeze  in  1  level; holds the snapshot and paging
disp_val  out  32  value for the hex decoder
page_hi  out  1  1 = high-byte page shown
src_idx  out  $clog2(NUM_SRC)  current source index

Behaviour:
- Reset (synchronous, rst=1 at a clk edge) sets: src_idx=0, snap=0, page=LO, refresh_cnt=0, dwell_cnt=0, btn_q=0, reload_pend=1. Outputs read disp_val=0, page_hi=0, src_idx=0.
- Edge detect: btn_q <= next_btn each cycle; rise = next_btn & ~btn_q. A held level produces exactly one rise.
- On rise:
  - src_idx <= (src_idx==NUM_SRC-1) ? 0 : src_idx+1.
  - reload_pend <= 1; page <= LO; dwell_cnt <= 0.
- refresh_cnt is free-running 0..REFRESH_CYCLES-1, wraps to 0, and ignores freeze. term = (refresh_cnt==REFRESH_CYCLES-1).
- Snapshot load condition: (term | reload_pend) & ~freeze. Action: snap <= source[src_idx] using the registered src_idx, and reload_pend <= 0.
  - Rise and load in the same cycle: the old source is loaded and reload_pend stays 1 (rise wins), so the new source loads the next cycle.
  - Consequence: disp_val shows the new source exactly 1 cycle after the rise cycle when freeze=0.
- Page FSM, states LO and HI:
  - If snap[31:24]==0: page forced to LO and dwell_cnt <= 0.
  - Else, if freeze=0: dwell_cnt increments. At DWELL_CYCLES-1 it wraps to 0 and page toggles LO<->HI.
  - freeze=1: dwell_cnt and page hold.
  - A rise overrides the paging rules (page <= LO, dwell_cnt <= 0).
- disp_val is combinational from registers:
  - LO: {8'h00, snap[23:0]}
  - HI: {24'h000000, snap[31:24]}
  - page_hi = (page==HI).
- The decoder overflow flag is therefore never set by this block.
- freeze:
  - Blocks snapshot loads but not source stepping; src_idx still advances and reload_pend stays 1.
  - On deassert, the pending reload occurs in the first cycle with freeze=0.
- Reset mid-operation (any state, any counter value) returns everything to reset values on the next edge; the first reload happens in the first cycle after rst deasserts.
- Latency summary: src change->display 1 cycle after the rise; source value change->display at the next term; page toggle every DWELL_CYCLES cycles.

Decomposition:
- Package hex_disp_pkg:
  - localparams PAGE_LO=1'b0, PAGE_HI=1'b1
  - HEX_DIGITS=6, DISP_BITS=24
  - HI_BYTE_MSB=31, HI_BYTE_LSB=24
- Sub-module tick_counter (parameter MAX; inputs clk, rst, en, clr; outputs count, term). Instantiated twice: refresh (en=1, clr=0) and dwell (en=paging&~freeze, clr=rise|~paging).

Test Plan:
(bench params NUM_SRC=3, REFRESH_CYCLES=4, DWELL_CYCLES=8)
1. rst 2 cycles, src0=32'h00123456 -> disp_val=32'h00123456 from cycle 1 after release; page_hi stays 0 for 100 cycles.
2. src0=32'hAB123456 -> disp_val 32'h00123456 for 8 cycles, then 32'h000000AB with page_hi=1 for 8 cycles; alternation repeats with period 16.
3. src0/1/2=1/2/3, three single-cycle next_btn pulses spaced 10 cycles -> src_idx 1,2,0; disp_val 2,3,1 one cycle after each rise; pulse during HI page -> page_hi=0 next cycle.
4. next_btn held high 20 cycles -> src_idx increments exactly once.
5. freeze=1, change src0 to 5 and press next_btn -> disp_val and page unchanged while src_idx=1. Release freeze -> disp_val=src1 on the first unfrozen cycle.
6. rst asserted during HI page with dwell_cnt=5 -> next cycle disp_val=0, page_hi=0, src_idx=0; cycle after release disp_val=src0.
